el2_lsu_ecc_wb: RTL



---
 rtl/el2_lsu_ecc_wb_if.sv | 41 ++++
 rtl/el2_lsu_ecc_wb.sv | 128 ++++++++++++
 2 files changed

// File: rtl/el2_lsu_ecc_wb_if.sv
// Port bundle for the DCCM ECC write-back engine: error-report side plus write-back request side.
// With EL2_ECC_WB_CNT_EN defined the bundle also carries the completed write-back counter.
interface el2_lsu_ecc_wb_if #(
   parameter int DCCM_BITS       = 16,
   parameter int DCCM_DATA_WIDTH = 32,
   parameter int DCCM_ECC_WIDTH  = 7
);
   logic                       err_valid;
   logic [DCCM_BITS-1:0]       err_addr;
   logic [DCCM_DATA_WIDTH-1:0] err_data;
   logic                       err_ready;
   logic                       dec_tlu_core_ecc_disable;
   logic                       wb_req;
   logic                       wb_gnt;
   logic [DCCM_BITS-1:0]       wb_addr;
   logic [DCCM_DATA_WIDTH-1:0] wb_data;
   logic [DCCM_ECC_WIDTH-1:0]  wb_ecc;
   logic                       wb_busy;
   logic                       err_ovf;
`ifdef EL2_ECC_WB_CNT_EN
   logic [15:0]                wb_cnt;
`endif

   // Engine side.
   modport master (
      input  err_valid, err_addr, err_data, dec_tlu_core_ecc_disable, wb_gnt,
      output err_ready, wb_req, wb_addr, wb_data, wb_ecc, wb_busy, err_ovf
`ifdef EL2_ECC_WB_CNT_EN
      , output wb_cnt
`endif
   );

   // Error reporter and DCCM write-port arbiter side.
   modport slave (
      output err_valid, err_addr, err_data, dec_tlu_core_ecc_disable, wb_gnt,
      input  err_ready, wb_req, wb_addr, wb_data, wb_ecc, wb_busy, err_ovf
`ifdef EL2_ECC_WB_CNT_EN
      , input wb_cnt
`endif
   );
endinterface

// File: rtl/el2_lsu_ecc_wb.sv
// DCCM single-error write-back engine: queues corrected words, regenerates SECDED bits, writes them back.
// Optional EL2_ECC_WB_CNT_EN adds a saturating count of completed write-backs.
module el2_lsu_ecc_wb #(
   parameter int DCCM_BITS       = 16,
   parameter int DCCM_DATA_WIDTH = 32,
   parameter int DCCM_ECC_WIDTH  = 7,
   parameter int WB_DEPTH        = 4
) (
   input logic              clk,
   input logic              rst_l,
   el2_lsu_ecc_wb_if.master bus
);
   localparam int AW = $clog2(WB_DEPTH);
   localparam int PW = AW + 1;

   typedef struct packed {
      logic [DCCM_BITS-1:0]       addr;
      logic [DCCM_DATA_WIDTH-1:0] data;
      logic [DCCM_ECC_WIDTH-1:0]  ecc;
   } entry_t;

   typedef enum logic {ST_IDLE, ST_REQ} state_t;

   // Hamming(38,32) check bits with data packed into the non-power-of-two positions, plus overall parity.
   function automatic logic [DCCM_ECC_WIDTH-1:0] ecc_gen(input logic [DCCM_DATA_WIDTH-1:0] d);
      logic [DCCM_ECC_WIDTH-1:0]  e;
      logic [DCCM_DATA_WIDTH-1:0] dd;
      e  = '0;
      dd = d;
      for (int p = 1; p <= 38; p++) begin
         if ((p & (p - 1)) != 0) begin
            for (int k = 0; k < 6; k++) begin
               if (((p >> k) & 1) != 0) e[k] = e[k] ^ dd[0];
            end
            dd = dd >> 1;
         end
      end
      e[6] = ^{d, e[5:0]};
      return e;
   endfunction

   entry_t         r_mem [WB_DEPTH];
   logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
   state_t         r_state, w_state_nxt;
   logic           r_ovf;

   logic [PW-1:0]        w_count;
   logic                 w_full, w_pop, w_report, w_match, w_push;
   logic [AW-1:0]        w_match_idx, w_off;
   logic [DCCM_BITS-1:0] w_addr;
   entry_t               w_entry, w_head;

   assign w_count  = r_wr_ptr - r_rd_ptr;
   assign w_full   = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop    = (r_state == ST_REQ) && bus.wb_gnt;
   assign w_report = bus.err_valid && !bus.dec_tlu_core_ecc_disable;
   assign w_addr   = bus.err_addr & ~DCCM_BITS'(3);
   assign w_entry  = {w_addr, bus.err_data, ecc_gen(bus.err_data)};
   assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

   // Coalesce target: any live entry with the same word address, except a head leaving this cycle.
   // NOTE: every always_comb output gets a default before any branch so no latch can be inferred.
   always_comb begin
      w_match     = 1'b0;
      w_match_idx = '0;
      w_off       = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         w_off = AW'(i) - r_rd_ptr[AW-1:0];
         if (!w_match && (PW'(w_off) < w_count) && !(w_pop && (w_off == '0)) &&
             (r_mem[i].addr == w_addr)) begin
            w_match     = 1'b1;
            w_match_idx = AW'(i);
         end
      end
   end

   assign w_push = w_report && !w_match && !w_full;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_push || (w_count != '0)) w_state_nxt = ST_REQ;
         ST_REQ:  if (w_pop && !w_push && (w_count == PW'(1))) w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         r_state  <= ST_IDLE;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         if (w_report && w_full && !w_match) r_ovf <= 1'b1;
      end
   end

   // NOTE: the entry array is not reset; pointers define liveness and outputs are gated by wb_req.
   always_ff @(posedge clk) begin
      if (w_push)                   r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
      else if (w_report && w_match) r_mem[w_match_idx]      <= w_entry;
   end

   assign bus.err_ready = !w_full;
   assign bus.wb_req    = (r_state == ST_REQ);
   assign bus.wb_addr   = bus.wb_req ? w_head.addr : '0;
   assign bus.wb_data   = bus.wb_req ? w_head.data : '0;
   assign bus.wb_ecc    = bus.wb_req ? w_head.ecc  : '0;
   assign bus.wb_busy   = (w_count != '0);
   assign bus.err_ovf   = r_ovf;

`ifdef EL2_ECC_WB_CNT_EN
   logic [15:0] r_wb_cnt;

   always_ff @(posedge clk) begin
      if (!rst_l)                          r_wb_cnt <= '0;
      else if (w_pop && (r_wb_cnt != 16'hFFFF)) r_wb_cnt <= r_wb_cnt + 16'd1;
   end

   assign bus.wb_cnt = r_wb_cnt;
`else
   // Build without the write-back counter.
`endif
endmodule
